// File: rtl/fft_pkg.sv
// Shared types and sizing constants for the FFT datapath.
package fft_pkg;

  localparam int unsigned FFT_POINTS = 64;
  localparam int unsigned FFT_LOG2   = 6;

  typedef logic [15:0] sample_t;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } streamer_state_t;

endpackage

// File: rtl/bit_reverse_index.sv
// Combinational bit reversal of a sample index; shared by the FFT loader and streamer.
module bit_reverse_index #(
  parameter int unsigned LOG_2_WIDTH = 6
) (
  input  logic [LOG_2_WIDTH-1:0] idx,
  output logic [LOG_2_WIDTH-1:0] rev_idx
);

  for (genvar i = 0; i < LOG_2_WIDTH; i++) begin : g_rev
    assign rev_idx[i] = idx[LOG_2_WIDTH-1-i];
  end

endmodule

// File: rtl/fft_result_streamer.sv
// Snapshots the butterfly result arrays on capture and streams them out one complex
// sample per cycle over valid/ready, in natural frequency order.
module fft_result_streamer
  import fft_pkg::*;
#(
  parameter int unsigned D_WIDTH     = FFT_POINTS,
  parameter int unsigned LOG_2_WIDTH = FFT_LOG2,
  parameter bit          BIT_REVERSE = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        capture,
  input  sample_t [D_WIDTH-1:0]       in_Re,
  input  sample_t [D_WIDTH-1:0]       in_Im,
  input  logic                        out_ready,
  output logic                        out_valid,
  output sample_t                     out_Re,
  output sample_t                     out_Im,
  output logic    [LOG_2_WIDTH-1:0]   out_index,
  output logic                        out_last,
  output logic                        busy,
  output logic                        overrun
);

  streamer_state_t        state_q, state_d;
  logic [LOG_2_WIDTH-1:0] idx_q, idx_d;
  logic [LOG_2_WIDTH-1:0] addr;
  sample_t                buf_re_q [D_WIDTH];
  sample_t                buf_im_q [D_WIDTH];
  logic                   overrun_q, overrun_d;
  logic                   load;
  logic                   streaming;
  logic                   xfer;
  logic                   at_last;

  assign streaming = (state_q == ST_STREAM);
  assign xfer      = streaming && out_ready;
  assign at_last   = (idx_q == LOG_2_WIDTH'(D_WIDTH - 1));

  // A capture is only accepted when idle or on the edge that retires the final bin.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    load      = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (xfer) begin
          if (at_last) begin
            idx_d = '0;
            if (capture) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        if (capture && !(xfer && at_last)) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < D_WIDTH; i++) begin
        buf_re_q[i] <= '0;
        buf_im_q[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < D_WIDTH; i++) begin
        buf_re_q[i] <= in_Re[i];
        buf_im_q[i] <= in_Im[i];
      end
    end
  end

  if (BIT_REVERSE) begin : g_addr_rev
    bit_reverse_index #(
      .LOG_2_WIDTH(LOG_2_WIDTH)
    ) u_bit_reverse_index (
      .idx     (idx_q),
      .rev_idx (addr)
    );
  end else begin : g_addr_nat
    assign addr = idx_q;
  end

  assign out_valid = streaming;
  assign out_Re    = streaming ? buf_re_q[addr] : '0;
  assign out_Im    = streaming ? buf_im_q[addr] : '0;
  assign out_index = idx_q;
  assign out_last  = streaming && at_last;
  assign busy      = streaming;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_fft_result_streamer.sv
// Scoreboard bench: a frame-level model queues expected samples on each accepted capture;
// a posedge monitor compares both streamer variants (bit-reversed and natural) against it.
module tb_fft_result_streamer;

  logic              clk;
  logic              rst;
  logic              capture;
  logic              out_ready;
  logic [63:0][15:0] in_re;
  logic [63:0][15:0] in_im;

  logic        valid_w [2];
  logic [15:0] re_w    [2];
  logic [15:0] im_w    [2];
  logic [5:0]  idx_w   [2];
  logic        last_w  [2];
  logic        busy_w  [2];
  logic        ovr_w   [2];

  int n_cmp = 0;
  int n_bad = 0;
  int xfer_cnt = 0;

  fft_result_streamer #(
    .D_WIDTH(64), .LOG_2_WIDTH(6), .BIT_REVERSE(1'b1)
  ) u_dut_rev (
    .clk(clk), .rst(rst), .capture(capture), .in_Re(in_re), .in_Im(in_im),
    .out_ready(out_ready), .out_valid(valid_w[0]), .out_Re(re_w[0]), .out_Im(im_w[0]),
    .out_index(idx_w[0]), .out_last(last_w[0]), .busy(busy_w[0]), .overrun(ovr_w[0])
  );

  fft_result_streamer #(
    .D_WIDTH(64), .LOG_2_WIDTH(6), .BIT_REVERSE(1'b0)
  ) u_dut_nat (
    .clk(clk), .rst(rst), .capture(capture), .in_Re(in_re), .in_Im(in_im),
    .out_ready(out_ready), .out_valid(valid_w[1]), .out_Re(re_w[1]), .out_Im(im_w[1]),
    .out_index(idx_w[1]), .out_last(last_w[1]), .busy(busy_w[1]), .overrun(ovr_w[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] re_rev;
    logic [15:0] im_rev;
    logic [15:0] re_nat;
    logic [15:0] im_nat;
    int          idx;
    bit          last;
  } exp_t;

  exp_t exp_q[$];
  bit   exp_ovr = 1'b0;

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %0h, required %0h", name, d, $time, act, req);
    end
  endtask

  function automatic int bitrev6(input int k);
    int r = 0;
    int v = k;
    for (int b = 0; b < 6; b++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int k = 0; k < 64; k++) begin
      e.re_rev = in_re[bitrev6(k)];
      e.im_rev = in_im[bitrev6(k)];
      e.re_nat = in_re[k];
      e.im_nat = in_im[k];
      e.idx    = k;
      e.last   = (k == 63);
      exp_q.push_back(e);
    end
  endtask

  // Monitor + model: outputs are stable between the active negedges, so the posedge view
  // is exactly what the next active edge will act on.
  always @(posedge clk) begin
    exp_t head;
    bit   has;
    if (!rst) begin
      exp_q.delete();
      exp_ovr = 1'b0;
    end else begin
      has = (exp_q.size() > 0);
      if (has) head = exp_q[0];
      for (int d = 0; d < 2; d++) begin
        check("out_valid", d, valid_w[d], has);
        check("busy", d, busy_w[d], has);
        check("overrun", d, ovr_w[d], exp_ovr);
        if (has) begin
          check("out_Re", d, re_w[d], (d == 0) ? head.re_rev : head.re_nat);
          check("out_Im", d, im_w[d], (d == 0) ? head.im_rev : head.im_nat);
          check("out_index", d, idx_w[d], head.idx);
          check("out_last", d, last_w[d], head.last);
        end
      end
      exp_ovr = 1'b0;
      if (has && out_ready) begin
        void'(exp_q.pop_front());
        xfer_cnt++;
      end
      if (capture) begin
        if (exp_q.size() == 0) push_frame();
        else exp_ovr = 1'b1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 64; i++) begin
      in_re[i] = 16'(i);
      in_im[i] = 16'(16'h100 + i);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) begin
      in_re[i] = 16'($urandom);
      in_im[i] = 16'($urandom);
    end
  endtask

  task automatic check_zero(input string name);
    for (int d = 0; d < 2; d++) begin
      check({name, ".out_valid"}, d, valid_w[d], 0);
      check({name, ".out_Re"}, d, re_w[d], 0);
      check({name, ".out_Im"}, d, im_w[d], 0);
      check({name, ".out_index"}, d, idx_w[d], 0);
      check({name, ".out_last"}, d, last_w[d], 0);
      check({name, ".busy"}, d, busy_w[d], 0);
      check({name, ".overrun"}, d, ovr_w[d], 0);
    end
  endtask

  task automatic pulse_capture();
    capture = 1'b1;
    step();
    capture = 1'b0;
  endtask

  // mode 0: ready held high, 1: pattern 1,0,0,1, 2: random
  task automatic run_until_idle(input int mode, input string name);
    int n = 0;
    while (valid_w[0] && n < 1000) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (n % 4 == 0) || (n % 4 == 3);
        default: out_ready = 1'($urandom % 2);
      endcase
      step();
      n++;
    end
    n_cmp++;
    if (valid_w[0]) begin
      n_bad++;
      $display("FAIL %s timeout: out_valid still %0b, required 0", name, valid_w[0]);
    end
  endtask

  task automatic wait_xfers(input int target, input string name);
    int n = 0;
    while (xfer_cnt < target && n < 1000) begin
      out_ready = 1'($urandom % 2);
      step();
      n++;
    end
    n_cmp++;
    if (xfer_cnt < target) begin
      n_bad++;
      $display("FAIL %s timeout: transfers %0d, required %0d", name, xfer_cnt, target);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int frames;
    rst       = 1'b1;
    capture   = 1'b0;
    out_ready = 1'b0;
    fill_ramp();
    #2 rst = 1'b0;
    #1 check_zero("reset");
    repeat (3) step();
    rst = 1'b1;
    repeat (10) begin
      out_ready = 1'($urandom % 2);
      step();
    end

    // Ramp frame, ready held high.
    out_ready = 1'b1;
    fill_ramp();
    pulse_capture();
    run_until_idle(0, "ramp");

    // Same ramp under 1,0,0,1 backpressure.
    pulse_capture();
    run_until_idle(1, "backpressure");

    // Overrun: second capture at transfer 10 with all-ones data.
    fill_ramp();
    base = xfer_cnt;
    pulse_capture();
    wait_xfers(base + 10, "overrun_wait");
    for (int i = 0; i < 64; i++) in_re[i] = 16'hFFFF;
    pulse_capture();
    run_until_idle(2, "overrun");

    // Back-to-back frames: capture on the edge that retires the last bin.
    fill_random();
    pulse_capture();
    frames = 3;
    for (int n = 0; n < 1000 && valid_w[0]; n++) begin
      capture   = 1'b0;
      out_ready = 1'($urandom % 2);
      if (last_w[0]) begin
        out_ready = 1'b1;
        if (frames > 0) begin
          fill_random();
          capture = 1'b1;
          frames--;
        end
      end
      step();
    end
    capture = 1'b0;
    run_until_idle(2, "back_to_back");

    // Reset at transfer 20, then a fresh frame.
    fill_random();
    base = xfer_cnt;
    pulse_capture();
    wait_xfers(base + 20, "mid_reset_wait");
    rst = 1'b0;
    #1 check_zero("mid_reset");
    step();
    step();
    rst = 1'b1;
    step();
    fill_random();
    pulse_capture();
    run_until_idle(2, "after_reset");

    // Random soak: random ready, sporadic captures, input arrays churning.
    for (int n = 0; n < 800; n++) begin
      out_ready = 1'($urandom % 2);
      capture   = ($urandom % 16 == 0);
      if ($urandom % 4 == 0) fill_random();
      step();
    end
    capture = 1'b0;
    run_until_idle(2, "soak");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_result_streamer.md
Name: fft_result_streamer

Overview:
Output side of the FFT datapath. Takes a parallel snapshot of the 64-point result arrays from the butterfly engine when a capture pulse arrives. It then streams the results out one complex sample per cycle over a valid/ready handshake, in natural frequency order. It frees the butterfly to accept a new frame as soon as the snapshot is taken.

Parameters:
D_WIDTH, 64, number of FFT points (power of two)
LOG_2_WIDTH, 6, log2(D_WIDTH); width of sample index
BIT_REVERSE, 1, 1 = emit buffer[bitrev(idx)]; 0 = emit buffer[idx]

Ports:
clk  input  1  system clock; all state updates on negedge clk, matching the butterfly engine
rst  input  1  asynchronous, active-low reset
capture  input  1  one-cycle pulse: butterfly result arrays are final, snapshot them
in_Re  input  16 x D_WIDTH  butterfly real result array
in_Im  input  16 x D_WIDTH  butterfly imaginary result array
out_ready  input  1  downstream can accept a sample
out_valid  output  1  out_Re/out_Im/out_index/out_last hold a valid sample
out_Re  output  16  real part of current sample
out_Im  output  16  imaginary part of current sample
out_index  output  LOG_2_WIDTH  frequency bin of current sample (the stream index idx, not the buffer address)
out_last  output  1  current sample is bin D_WIDTH-1
busy  output  1  a frame is held or streaming (state == STREAM)
overrun  output  1  one-cycle pulse: a capture was dropped

Behaviour:
- Reset (rst low, asynchronous): state IDLE; idx 0; snapshot buffer all zero.
- Output values in reset: out_valid 0, out_Re 0, out_Im 0, out_index 0, out_last 0, busy 0, overrun 0.
- Event order at each active edge: reset first, then the transfer test, then capture.
- IDLE state:
  - capture=1: copy every in_Re[i]/in_Im[i] into buffer[i], set idx=0, go to STREAM.
  - out_valid rises one active edge after capture (latency 1).
- STREAM state:
  - out_valid=1 for the whole state.
  - Sample presented: out_Re/out_Im = buffer[addr], where addr = bitrev(idx) if BIT_REVERSE else idx.
  - out_index = idx; out_last = (idx == D_WIDTH-1).
- Transfer rule:
  - A transfer occurs on an active edge with out_valid & out_ready; idx increments by 1 (LOG_2_WIDTH-bit).
  - While out_valid & !out_ready, all outputs stay stable. No sample is ever skipped or duplicated.
- End of frame: transfer with out_last=1:
  - No capture in the same cycle: go to IDLE, idx=0, out_valid falls next edge.
  - Capture in the same cycle: reload the buffer from in_Re/in_Im, idx=0, stay in STREAM. out_valid stays high with no bubble, and bin 0 of the new frame is presented next.
- Capture in STREAM, not coinciding with the last transfer:
  - The capture is ignored; buffer is unchanged.
  - overrun pulses high for exactly one cycle.
- Buffer writes happen only on an accepted capture. in_Re/in_Im may change freely at any other time without affecting the stream.
- Reset mid-stream: immediate return to IDLE with all outputs at reset values; the partial frame is discarded.
- out_ready is ignored in IDLE.
- Arithmetic and width rules:
  - Samples pass through bit-exact, 16-bit, with no scaling.
  - idx wraps from D_WIDTH-1 to 0 only through the end-of-frame rule.
- Throughput: one sample per cycle when out_ready is held high, so D_WIDTH cycles per frame.

Decomposition:
- Package fft_pkg holds:
  - Constants FFT_POINTS=64 and FFT_LOG2=6.
  - typedef logic [15:0] sample_t.
  - typedef enum logic {ST_IDLE, ST_STREAM} streamer_state_t.
- Sub-module bit_reverse_index: combinational, parameter LOG_2_WIDTH, input idx, output reversed index. It is shared with the future input loader.
- The streamer itself contains:
  - the state register;
  - the idx counter;
  - a D_WIDTH-entry buffer for each of Re and Im;
  - one read multiplexer per component.

Test Plan:
- Reset then idle: with rst low, every output is 0. After rst is released and capture is held 0 for 10 cycles, out_valid and busy stay 0.
- Bit-reversed stream:
  - Stimulus: BIT_REVERSE=1, in_Re[i]=i, in_Im[i]=16'h100+i, capture pulse, out_ready held 1.
  - Required: 64 consecutive transfers. Transfer k has out_index=k, out_Re=bitrev6(k), out_Im=16'h100+bitrev6(k). For example k=1 gives out_Re=32, out_Im=16'h120.
  - out_last is high only at k=63; busy drops one edge after that transfer.
- Natural order with backpressure:
  - Stimulus: BIT_REVERSE=0, same input arrays, out_ready toggling 1,0,0,1.
  - Required: outputs stay stable during stall cycles, and the transfer sequence is exactly out_Re=0..63 with no gaps or duplicates.
- Overrun:
  - Stimulus: a second capture at transfer 10 with new input data (in_Re[i]=16'hFFFF).
  - Required: overrun is high for one cycle, and the remaining transfers still carry the first frame's values.
- Back-to-back frames:
  - Stimulus: capture asserted on the same edge as the transfer with out_last=1.
  - Required: out_valid never drops, and the next transfer is bin 0 of the new frame.
- Reset mid-stream:
  - Stimulus: rst pulsed low at transfer 20.
  - Required: outputs go to 0 immediately. A fresh capture after release restarts the stream at out_index=0.
